intr_ctrl: RTL and testbench
============================

# intr_ctrl

Parametrised vectored interrupt controller that sits between peripheral interrupt sources and the pipelined CPU's single `intr`/`inta` pair. It collects `NUM_CH` request lines, with per-channel edge or level mode, masks them, and picks the highest-priority pending channel. It then runs the request/acknowledge handshake with the CPU and presents a handler vector address. Successor to the single-line `intr` stimulus: same CPU-side handshake, generalised to N channels with priority, masking, pending capture and end-of-interrupt.

## Interface
- `NUM_CH`, 8: number of interrupt channels (2..32).
- `ID_W`, 3: channel-id width, equal to ceil(log2(NUM_CH)).
- `EDGE_MASK`, 8'hFF: per-channel mode. 1 = rising-edge, 0 = level-high.
- `VEC_BASE`, 32'h0000_0008: handler vector for channel 0.
- `VEC_STRIDE`, 32'd4: byte distance between consecutive channel vectors.

- `Clock` in 1: single clock, rising edge.
- `Resetn` in 1: synchronous, active-low reset.
- `irq` in NUM_CH: raw requests, synchronous to `Clock`.
- `mask_we` in 1: write strobe for the mask register.
- `mask_wdata` in NUM_CH: new mask value; 1 = channel masked.
- `mask` out NUM_CH: current mask.
- `pending` out NUM_CH: current pending register.
- `intr` out 1: interrupt request to the CPU.
- `inta` in 1: one-cycle acknowledge from the CPU.
- `int_id` out ID_W: id of the acknowledged channel.
- `vector` out 32: handler address, `VEC_BASE + int_id*VEC_STRIDE`, mod 2^32.
- `in_service` out 1: a handler is active.
- `eoi` in 1: one-cycle end-of-interrupt from the CPU.

## Operation
- **Reset** (`Resetn`=0 at an edge) sets: `mask`=0, `pending`=0, `irq_prev`=0, state IDLE, `intr`=0, `int_id`=0, `vector`=VEC_BASE, `in_service`=0. Reset in any state aborts the handshake immediately.
- **Edge channels:** `pending[i]` is set when `irq[i]` is 1 and `irq_prev[i]` is 0. It is cleared only when that channel is acknowledged. If a set and a clear hit the same channel in the same cycle, the set wins.
- **Level channels:** `pending[i]` is the registered copy of `irq[i]`. Acknowledge does not clear it; the source must drop the line before `eoi`.
- **Candidate set:** `req = pending & ~mask`. The winner is the lowest set index (channel 0 has highest priority).
- **State IDLE:** if `req` is nonzero, go to REQ and set `intr`=1. `inta` and `eoi` are ignored.
- **State REQ:** `intr` is held at 1. The winner is re-evaluated every cycle, so a higher-priority arrival before `inta` takes over.
  - If `req` becomes 0 (level drop or mask write), clear `intr` and return to IDLE. The request is withdrawn.
  - On `inta`=1: latch `int_id` = current winner and load `vector`. Clear the edge-mode pending bit. Clear `intr`, set `in_service`, go to SERVICE.
- **State SERVICE:** no nesting, and `intr` stays 0. New edges still accumulate in `pending`.
  - On `eoi`=1, clear `in_service` and go to IDLE.
  - `inta` is ignored.
  - `int_id` and `vector` hold until the next acknowledge.
- **Mask writes** are allowed in any state. They change arbitration from the next cycle and never clear `pending`.

## Timing
- `irq` rises at edge t. `pending` updates at edge t+1. `intr`=1 is visible after edge t+2 (latency 2 cycles).
- `inta` sampled high at edge k. `intr`=0, `in_service`=1, and `int_id`/`vector` become valid after edge k.
- `eoi` sampled at edge m puts the block in IDLE after m. If `req` is still nonzero, `intr`=1 again after edge m+1.
- `eoi` and `inta` in the same cycle: only the input that is legal in the current state acts.
- Overlapping edges are not counted: a second edge on an already-pending edge channel is merged into the first.
- `mask_we` together with `inta` in REQ: arbitration uses the old mask in that cycle.

## Structure
- Package `intr_pkg` holds:
  - the state enum: IDLE=2'b00, REQ=2'b01, SERVICE=2'b10;
  - the default `VEC_BASE` and `VEC_STRIDE` constants;
  - a function computing `ID_W` from `NUM_CH`.
- Sub-module `intr_prio_enc`: parametrised combinational lowest-index priority encoder with outputs `any` and `id`.
- The top level holds the edge detector, the pending/mask registers, the FSM and the vector computation.

## Test plan
- **Reset:** hold `Resetn`=0 for 3 cycles with `irq`=8'hFF, then release → all outputs at their reset values. `intr` rises 2 cycles after release.
- **Single edge:** pulse `irq[5]` for one cycle → `intr`=1 two cycles later. `inta` → `int_id`=5, `vector`=0x1C, `pending[5]`=0, `in_service`=1. `eoi` → IDLE with `intr`=0.
- **Priority:** `irq[6]` at t, `irq[2]` at t+3, `inta` at t+5 → `int_id`=2, `vector`=0x10. After `eoi`, `intr` reasserts and the next `inta` gives `int_id`=6.
- **Masking:** set `mask`=8'h08, pulse `irq[3]` → `intr` stays 0 and `pending[3]`=1. Write `mask`=0 → `intr`=1 two cycles later.
- **Level withdraw:** `EDGE_MASK`=0. Raise `irq[1]`, wait for `intr`, drop `irq[1]` before `inta` → `intr` returns to 0 and state is IDLE. `inta` pulsed in IDLE → no change.
- **Reset mid-service:** `Resetn`=0 while in SERVICE → `in_service`=0, `pending`=0, `int_id`=0.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared types and defaults for the vectored interrupt controller.
package intr_pkg;

    // Handshake states; encodings are fixed so debug taps stay stable.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } intr_state_e;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0008;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'd4;

    // Channel-id width for n channels; never below one bit.
    function automatic int calc_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder: channel 0 has the highest priority.
module intr_prio_enc #(
    parameter int NUM_CH = 8,
    parameter int ID_W   = 3
) (
    input  logic [NUM_CH-1:0] i_req,
    output logic              o_any,
    output logic [ID_W-1:0]   o_id
);

    // Scan from the top down so the lowest set index is the last to write o_id.
    always_comb begin
        o_any = |i_req;
        o_id  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_req[i]) o_id = ID_W'(i);
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Vectored interrupt controller: edge/level capture, masking, priority pick
// and the intr/inta/eoi handshake with a single CPU interrupt line.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int                NUM_CH     = 8,
    parameter int                ID_W       = calc_id_w(NUM_CH),
    parameter logic [NUM_CH-1:0] EDGE_MASK  = {NUM_CH{1'b1}},
    parameter logic [31:0]       VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0]       VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [NUM_CH-1:0] irq,
    input  logic              mask_we,
    input  logic [NUM_CH-1:0] mask_wdata,
    output logic [NUM_CH-1:0] mask,
    output logic [NUM_CH-1:0] pending,
    output logic              intr,
    input  logic              inta,
    output logic [ID_W-1:0]   int_id,
    output logic [31:0]       vector,
    output logic              in_service,
    input  logic              eoi
);

    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_irq_prev;
    intr_state_e       r_state;
    logic              r_intr;
    logic [ID_W-1:0]   r_int_id;
    logic [31:0]       r_vector;
    logic              r_in_service;

    logic [NUM_CH-1:0] w_req;
    logic              w_any;
    logic [ID_W-1:0]   w_win_id;
    logic              w_ack;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] w_pend_nxt;
    logic [31:0]       w_vec;

    // Arbitration works on registered state only, so a mask write in the
    // acknowledge cycle still sees the old mask.
    assign w_req = r_pending & ~r_mask;

    intr_prio_enc #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_prio (
        .i_req (w_req),
        .o_any (w_any),
        .o_id  (w_win_id)
    );

    // An acknowledge only counts while a request is actually outstanding.
    assign w_ack  = (r_state == REQ) && w_any && inta;
    assign w_rise = irq & ~r_irq_prev;
    assign w_clr  = w_ack ? (ONE_HOT0 << w_win_id) : '0;

    // Edge channels: set-wins over ack clear. Level channels just track the line.
    assign w_pend_nxt = (EDGE_MASK & ((r_pending & ~w_clr) | w_rise))
                      | (~EDGE_MASK & irq);

    assign w_vec = VEC_BASE + VEC_STRIDE * 32'(w_win_id);

    // Mask register, writable in any state.
    always_ff @(posedge Clock) begin
        if (!Resetn)      r_mask <= '0;
        else if (mask_we) r_mask <= mask_wdata;
    end

    // Edge detector history and pending capture.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_pending  <= '0;
            r_irq_prev <= '0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_irq_prev <= irq;
        end
    end

    // Request/acknowledge/end-of-interrupt handshake with registered outputs.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state      <= IDLE;
            r_intr       <= 1'b0;
            r_int_id     <= '0;
            r_vector     <= VEC_BASE;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= REQ;
                        r_intr  <= 1'b1;
                    end
                end
                REQ: begin
                    if (!w_any) begin
                        r_state <= IDLE;
                        r_intr  <= 1'b0;
                    end else if (inta) begin
                        r_state      <= SERVICE;
                        r_intr       <= 1'b0;
                        r_in_service <= 1'b1;
                        r_int_id     <= w_win_id;
                        r_vector     <= w_vec;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        r_state      <= IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_intr  <= 1'b0;
                end
            endcase
        end
    end

    assign mask       = r_mask;
    assign pending    = r_pending;
    assign intr       = r_intr;
    assign int_id     = r_int_id;
    assign vector     = r_vector;
    assign in_service = r_in_service;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench: one all-edge instance and one all-level instance.
module tb_intr_ctrl;

    logic       Clock = 1'b0;
    logic       Resetn;

    // all-edge instance
    logic [7:0] irq, mask_wdata, mask, pending;
    logic       mask_we, intr, inta, in_service, eoi;
    logic [2:0] int_id;
    logic [31:0] vector;

    // all-level instance
    logic [7:0] l_irq, l_mask_wdata, l_mask, l_pending;
    logic       l_mask_we, l_intr, l_inta, l_in_service, l_eoi;
    logic [2:0] l_int_id;
    logic [31:0] l_vector;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    intr_ctrl u_edge (
        .Clock(Clock), .Resetn(Resetn), .irq(irq), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .mask(mask), .pending(pending), .intr(intr),
        .inta(inta), .int_id(int_id), .vector(vector),
        .in_service(in_service), .eoi(eoi)
    );

    intr_ctrl #(.EDGE_MASK(8'h00)) u_lvl (
        .Clock(Clock), .Resetn(Resetn), .irq(l_irq), .mask_we(l_mask_we),
        .mask_wdata(l_mask_wdata), .mask(l_mask), .pending(l_pending),
        .intr(l_intr), .inta(l_inta), .int_id(l_int_id), .vector(l_vector),
        .in_service(l_in_service), .eoi(l_eoi)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Resetn = 1'b0;
        irq = 8'hFF; mask_we = 0; mask_wdata = 0; inta = 0; eoi = 0;
        l_irq = 0; l_mask_we = 0; l_mask_wdata = 0; l_inta = 0; l_eoi = 0;

        // ---- reset ----
        tick(); tick(); tick();
        chk("rst_mask", 32'(mask), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_intr", 32'(intr), 0);
        chk("rst_id", 32'(int_id), 0);
        chk("rst_vec", vector, 32'h8);
        chk("rst_insvc", 32'(in_service), 0);
        Resetn = 1'b1;
        tick();
        chk("rel_pend", 32'(pending), 32'hFF);
        chk("rel_intr1", 32'(intr), 0);
        tick();
        chk("rel_intr2", 32'(intr), 1);
        Resetn = 1'b0; irq = 0;
        tick();
        Resetn = 1'b1;

        // ---- single edge on channel 5 ----
        irq = 8'h20;
        tick(); irq = 0;
        chk("se_pend", 32'(pending), 32'h20);
        chk("se_intr0", 32'(intr), 0);
        tick();
        chk("se_intr1", 32'(intr), 1);
        inta = 1;
        tick(); inta = 0;
        chk("se_id", 32'(int_id), 5);
        chk("se_vec", vector, 32'h1C);
        chk("se_pend_clr", 32'(pending), 0);
        chk("se_insvc", 32'(in_service), 1);
        chk("se_intr_ack", 32'(intr), 0);
        inta = 1;               // ignored in SERVICE
        tick(); inta = 0;
        chk("se_hold_id", 32'(int_id), 5);
        chk("se_hold_svc", 32'(in_service), 1);
        eoi = 1;
        tick(); eoi = 0;
        chk("se_eoi_svc", 32'(in_service), 0);
        tick();
        chk("se_idle_intr", 32'(intr), 0);

        // ---- priority: 6 first, 2 arrives before inta ----
        irq = 8'h40;
        tick(); irq = 0;
        tick();
        chk("pr_intr", 32'(intr), 1);
        tick();
        irq = 8'h04;
        tick(); irq = 0;
        chk("pr_pend", 32'(pending), 32'h44);
        tick();
        inta = 1;
        tick(); inta = 0;
        chk("pr_id2", 32'(int_id), 2);
        chk("pr_vec2", vector, 32'h10);
        chk("pr_pend6", 32'(pending), 32'h40);
        eoi = 1;
        tick(); eoi = 0;
        chk("pr_eoi_intr", 32'(intr), 0);
        tick();
        chk("pr_reassert", 32'(intr), 1);
        inta = 1;
        tick(); inta = 0;
        chk("pr_id6", 32'(int_id), 6);
        chk("pr_vec6", vector, 32'h20);
        chk("pr_pend0", 32'(pending), 0);
        eoi = 1;
        tick(); eoi = 0;

        // ---- new edge in the ack cycle: set beats clear ----
        irq = 8'h20;
        tick(); irq = 0;
        tick();
        irq = 8'h00;
        tick();                 // irq low so the next rise is a fresh edge
        irq = 8'h20; inta = 1;
        tick(); irq = 0; inta = 0;
        chk("sw_id", 32'(int_id), 5);
        chk("sw_pend", 32'(pending), 32'h20);
        eoi = 1;
        tick(); eoi = 0;
        tick();
        chk("sw_reassert", 32'(intr), 1);
        inta = 1;
        tick(); inta = 0;
        chk("sw_pend0", 32'(pending), 0);
        eoi = 1;
        tick(); eoi = 0;

        // ---- masking ----
        mask_we = 1; mask_wdata = 8'h08;
        tick(); mask_we = 0;
        chk("mk_mask", 32'(mask), 32'h08);
        irq = 8'h08;
        tick(); irq = 0;
        tick(); tick();
        chk("mk_pend", 32'(pending), 32'h08);
        chk("mk_intr0", 32'(intr), 0);
        mask_we = 1; mask_wdata = 8'h00;
        tick(); mask_we = 0;
        chk("mk_unmask_intr", 32'(intr), 0);
        tick();
        chk("mk_intr1", 32'(intr), 1);
        mask_we = 1; mask_wdata = 8'h08;   // withdraw via mask
        tick(); mask_we = 0;
        chk("mk_oldmask_intr", 32'(intr), 1);
        tick();
        chk("mk_withdraw", 32'(intr), 0);
        chk("mk_pend_kept", 32'(pending), 32'h08);
        mask_we = 1; mask_wdata = 8'h00;
        tick(); mask_we = 0;
        tick();
        chk("mk_intr2", 32'(intr), 1);
        mask_we = 1; mask_wdata = 8'h08; inta = 1;  // old mask arbitrates
        tick(); mask_we = 0; inta = 0;
        chk("mk_ack_id", 32'(int_id), 3);
        chk("mk_ack_svc", 32'(in_service), 1);
        mask_we = 1; mask_wdata = 8'h00; eoi = 1;
        tick(); mask_we = 0; eoi = 0;
        tick();
        chk("mk_done_intr", 32'(intr), 0);

        // ---- level withdraw on the level instance ----
        l_irq = 8'h02;
        tick(); tick();
        chk("lv_intr", 32'(l_intr), 1);
        l_irq = 0;
        tick(); tick();
        chk("lv_withdraw", 32'(l_intr), 0);
        chk("lv_pend0", 32'(l_pending), 0);
        l_inta = 1;
        tick(); l_inta = 0;
        chk("lv_idle_inta_svc", 32'(l_in_service), 0);
        chk("lv_idle_inta_id", 32'(l_int_id), 0);
        chk("lv_idle_inta_vec", l_vector, 32'h8);
        l_irq = 8'h02;
        tick(); tick();
        l_inta = 1;
        tick(); l_inta = 0;
        chk("lv_ack_id", 32'(l_int_id), 1);
        chk("lv_ack_vec", l_vector, 32'hC);
        chk("lv_pend_kept", 32'(l_pending), 32'h02);
        l_irq = 0;
        tick();
        l_eoi = 1;
        tick(); l_eoi = 0;
        tick();
        chk("lv_eoi_intr", 32'(l_intr), 0);
        chk("lv_eoi_svc", 32'(l_in_service), 0);

        // ---- reset mid-service ----
        irq = 8'h02;
        tick(); irq = 0;
        tick();
        inta = 1;
        tick(); inta = 0;
        chk("rs_svc", 32'(in_service), 1);
        chk("rs_id", 32'(int_id), 1);
        irq = 8'h80;
        tick(); irq = 0;
        chk("rs_accum", 32'(pending), 32'h80);
        Resetn = 1'b0;
        tick(); Resetn = 1'b1;
        chk("rs_insvc0", 32'(in_service), 0);
        chk("rs_pend0", 32'(pending), 0);
        chk("rs_id0", 32'(int_id), 0);
        chk("rs_vec0", vector, 32'h8);
        chk("rs_intr0", 32'(intr), 0);
        tick();
        chk("rs_idle", 32'(intr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
